booth_mul_seq: RTL and testbench



---
 rtl/booth_mul_seq.sv | 119 +++++++++++
 tb/tb_booth_mul_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a shared accumulator,
// valid/ready handshake on operands and product, signed or unsigned per operation.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_tc,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  localparam int unsigned XW   = WIDTH + 2;
  localparam int unsigned NDIG = WIDTH / 2 + 1;
  localparam int unsigned ACCW = 2 * WIDTH + 4;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [XW-1:0]     a_q, b_q;
  logic [ACCW-1:0]   acc_q, acc_next;
  logic [CW-1:0]     cnt_q;

  logic [XW:0]       bz;
  logic [2:0]        digit;
  logic              neg, two, zero;
  logic [XW:0]       mag, ppm;
  logic [ACCW-1:0]   ppx;
  logic [CW:0]       sh;

  // Digit k looks at extended b bits [2k+1:2k-1]; the appended zero supplies bit -1.
  assign bz    = {b_q, 1'b0};
  assign sh    = {cnt_q, 1'b0};
  assign digit = 3'(bz >> sh);

  always_comb begin
    neg  = digit[2] & ~(digit[1] & digit[0]);
    two  = (digit == 3'b011) || (digit == 3'b100);
    zero = (digit == 3'b000) || (digit == 3'b111);
    mag  = '0;
    if (!zero) begin
      mag = two ? {a_q, 1'b0} : {a_q[XW-1], a_q};
    end
    // Negation is invert here plus a carry-in at bit 2k on the same add.
    ppm      = neg ? ~mag : mag;
    ppx      = ACCW'({{(ACCW-XW-1){ppm[XW]}}, ppm});
    acc_next = acc_q + (ppx << sh) + (ACCW'(neg) << sh);
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      busy        <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d == BUSY);
      if (accept) begin
        a_q   <= {{2{in_tc & in_a[WIDTH-1]}}, in_a};
        b_q   <= {{2{in_tc & in_b[WIDTH-1]}}, in_b};
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CW'(1);
      end
      if ((state_q == BUSY) && (state_d == DONE)) begin
        out_product <= acc_next[PW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and table-driven bench for booth_mul_seq: a WIDTH=16 instance plus a bank of
// WIDTH=8 instances sharing the sweep of all operand pairs in both modes.
module tb_booth_mul_seq;

  localparam int unsigned NI8 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;

  logic        in_valid, in_ready, in_tc, out_valid, busy;
  logic [15:0] in_a, in_b;
  logic [31:0] out_product;

  logic           v8, tc8;
  logic [7:0]     a8;
  logic [7:0]     b8 [NI8];
  logic [15:0]    p8 [NI8];
  logic [NI8-1:0] ir8, ov8, bs8;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tc(in_tc),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy)
  );

  for (genvar g = 0; g < NI8; g++) begin : g_w8
    booth_mul_seq #(.WIDTH(8)) u (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8[g]), .in_tc(tc8),
      .in_a(a8), .in_b(b8[g]), .out_valid(ov8[g]), .out_ready(out_ready),
      .out_product(p8[g]), .busy(bs8[g])
    );
  end

  typedef struct {
    logic        tc;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic on w-bit operands.
  function automatic logic [31:0] ref_mul(input logic tc, input int w,
                                          input logic [15:0] a, input logic [15:0] b);
    longint m, sa, sb;
    m  = longint'(1) << w;
    sa = longint'(a) & (m - 1);
    sb = longint'(b) & (m - 1);
    if (tc) begin
      if (sa >= m / 2) sa -= m;
      if (sb >= m / 2) sb -= m;
    end
    return 32'(sa * sb);
  endfunction

  task automatic wait_ov(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic wait_ov8(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ov8 != '1 && lat < 40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] hold, exp;
    logic        tcr [100];
    logic [15:0] ar [100];
    logic [15:0] br [100];

    vt[0] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
    vt[1] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
    vt[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vt[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    vt[4] = '{1'b0, 16'h0000, 16'h1234, 32'h0000_0000};
    vt[5] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
    vt[6] = '{1'b0, 16'h8000, 16'h0002, 32'h0001_0000};
    vt[7] = '{1'b1, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1};
    vt[8] = '{1'b0, 16'h1234, 16'h0010, 32'h0001_2340};

    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_tc = 1'b0; in_a = '0; in_b = '0;
    v8 = 1'b0; tc8 = 1'b0; a8 = '0;
    for (int j = 0; j < NI8; j++) b8[j] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_product", out_product, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset w8 in_ready", ir8, {NI8{1'b1}});

    // Table vectors; operands scrambled while busy must not matter.
    for (int i = 0; i < 9; i++) begin
      in_tc = vt[i].tc; in_a = vt[i].a; in_b = vt[i].b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 16'h5A5A; in_b = 16'hA5A5; in_tc = ~vt[i].tc;
      chk("vec busy", busy, 1);
      wait_ov(lat);
      chk("vec latency", 64'(lat), 64'd9);
      chk("vec product", out_product, vt[i].p);
    end

    // Backpressure: hold the last table product for 5 cycles with a new op pending.
    out_ready = 1'b0;
    in_tc = 1'b1; in_a = 16'h1234; in_b = 16'hFEDC; in_valid = 1'b1;
    exp = ref_mul(1'b1, 16, 16'h1234, 16'hFEDC);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp out_valid", out_valid, 1);
      chk("bp product", out_product, vt[8].p);
      chk("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp handoff out_valid", out_valid, 0);
    chk("bp handoff busy", busy, 1);
    wait_ov(lat);
    chk("bp latency", 64'(lat), 64'd9);
    chk("bp product", out_product, exp);

    // Back-to-back random ops with out_ready tied high.
    for (int i = 0; i < 100; i++) begin
      tcr[i] = 1'($urandom);
      ar[i]  = 16'($urandom);
      br[i]  = 16'($urandom);
    end
    for (int i = 0; i < 100; i++) begin
      in_tc = tcr[i]; in_a = ar[i]; in_b = br[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 16'($urandom); in_b = 16'($urandom); in_tc = ~tcr[i];
      in_valid = (i < 99);
      wait_ov(lat);
      chk("b2b latency", 64'(lat), 64'd9);
      chk("b2b product", out_product, ref_mul(tcr[i], 16, ar[i], br[i]));
      chk("b2b in_ready", in_ready, 1);
    end

    // Reset four cycles into BUSY discards the op.
    in_tc = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_product", out_product, 0);
    chk("midrst busy", busy, 0);
    in_tc = 1'b1; in_a = 16'h0003; in_b = 16'hFFFB; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ov(lat);
    chk("post-rst latency", 64'(lat), 64'd9);
    chk("post-rst product", out_product, 32'hFFFF_FFF1);

    // WIDTH=8 sweep of every (mode, a, b): instance j covers b[7:3] = j.
    for (int idx = 0; idx < 4096; idx++) begin
      logic [11:0] ix;
      int          bad;
      logic [15:0] e8;
      ix  = 12'(idx);
      tc8 = ix[11]; a8 = ix[10:3];
      for (int j = 0; j < NI8; j++) b8[j] = {5'(j), ix[2:0]};
      v8 = 1'b1;
      @(posedge clk); #1;
      v8 = (idx < 4095);
      chk("w8 accept busy", {ov8, bs8}, {{NI8{1'b0}}, {NI8{1'b1}}});
      wait_ov8(lat);
      chk("w8 latency", 64'(lat), 64'd5);
      bad = 0;
      for (int j = 0; j < NI8; j++) begin
        if (p8[j] !== 16'(ref_mul(tc8, 8, {8'h00, a8}, {8'h00, b8[j]}))) begin
          bad = j;
          break;
        end
      end
      e8 = 16'(ref_mul(tc8, 8, {8'h00, a8}, {8'h00, b8[bad]}));
      chk("w8 product", p8[bad], e8);
    end
    chk("w8 done in_ready", ir8, {NI8{1'b1}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
